// File: rtl/divisor_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH : default operand / quotient / remainder width
//   CNT_W     : iteration counter width for DIV_WIDTH
//   state_e   : control FSM states (2'b11 is unused and recovers to IDLE)
package divisor_seq_pkg;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/divisor_seq_resta_pas.sv
// Combinational ripple subtractor step: diff = x + ~y + 1.
//   x, y : W-bit unsigned operands
//   diff : W-bit difference (modulo 2^W)
//   c    : carry-out; 1 means x >= y (no borrow)
module divisor_seq_resta_pas #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] diff,
    output logic         c
);

    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    end

    assign diff = sum[W-1:0];
    assign c    = sum[W];

endmodule

// File: rtl/divisor_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, sampled only in IDLE together with a (dividend) and b (divisor)
//   busy     : high while iterating
//   done     : one-cycle pulse when q / r / div0 are updated
//   q, r     : registered quotient and remainder, held until the next result
//   div0     : last accepted request had b == 0 (q = all ones, r = a)
module divisor_seq
    import divisor_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div0
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_q, state_d;
    logic [WIDTH:0]    rem_q, rem_d;   // partial remainder, one spare bit for the shift-in
    logic [WIDTH-1:0]  quo_q, quo_d;   // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]  den_q, den_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic              div0_q, div0_d;

    logic [WIDTH:0]    trial_x, trial_y, trial_diff;
    logic              trial_c;

    // Remainder stays below the divisor, so the top bit of rem_q is never needed for the shift.
    logic              unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    assign trial_x = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial_y = {1'b0, den_q};

    divisor_seq_resta_pas #(
        .W (WIDTH + 1)
    ) u_resta_pas (
        .x    (trial_x),
        .y    (trial_y),
        .diff (trial_diff),
        .c    (trial_c)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d = a;
                    den_d = b;
                    rem_d = '0;
                    cnt_d = '0;
                    if (b == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = a;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Carry-out of the trial subtraction is the quotient bit.
                rem_d = trial_c ? trial_diff : trial_x;
                quo_d = {quo_q[WIDTH-2:0], trial_c};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = DONE;
                    q_d     = quo_d;
                    r_d     = rem_d[WIDTH-1:0];
                    div0_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign q    = q_q;
    assign r    = r_q;
    assign div0 = div0_q;

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
Sequential unsigned restoring divider that computes a / b and produces a quotient and a remainder. It is the inverse operation of the team's adder/subtractor datapath: each step uses a ripple subtractor (a + ~b + 1) and reads its carry-out as the "a >= b" decision. It performs one quotient bit per clock and sits beside the subtractor in the ALU as the multi-cycle division unit. Handshake is start/busy/done.

Parameters:
WIDTH, 16, operand, quotient and remainder width in bits.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  request a division; sampled only in IDLE.
a  in  WIDTH  dividend; sampled with start.
b  in  WIDTH  divisor; sampled with start.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse when q/r/div0 become valid.
q  out  WIDTH  quotient; registered.
r  out  WIDTH  remainder; registered.
div0  out  1  high when the last accepted request had b == 0.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy = 0, done = 0, q = 0, r = 0, div0 = 0.
  - Internal registers R, Q, D and cnt are cleared.
  - Reset in the middle of RUN aborts the division with no result; a new start is required.
- States: IDLE, RUN, DONE.
- IDLE, start = 1 at edge N:
  - Load Q = a, D = b, R = 0 (WIDTH+1 bits), cnt = 0.
  - If b == 0: go to DONE. At that same edge set q = all ones, r = a, div0 = 1.
  - Otherwise go to RUN.
- RUN, each edge performs one iteration:
  - Form S = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits).
  - Compute T = S + ~{1'b0, D} + 1 in WIDTH+1 bits, with carry-out c.
  - If c == 1 (S >= D): R = T, Q = {Q[WIDTH-2:0], 1}.
  - Else: R = S, Q = {Q[WIDTH-2:0], 0}.
  - cnt increments by 1.
  - On the edge that completes iteration WIDTH (cnt == WIDTH-1 before the edge), go to DONE. At that edge latch q = new Q, r = new R[WIDTH-1:0], div0 = 0.
- DONE: done = 1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency:
  - Normal case: done is high in the cycle after edge N+WIDTH, i.e. 16 iterations plus the load edge.
  - b == 0 case: done is high in the cycle after edge N.
- busy = 1 exactly in RUN; done = 1 exactly in DONE.
- start is ignored in RUN and DONE. There is no queuing and a, b may change freely during those states.
- q, r and div0 hold their last result until the next DONE entry or reset; they do not change during RUN.
- Invariant for b != 0: q*b + r == a and r < b.
- Boundaries:
  - a = 0 gives q = 0, r = 0.
  - b = 1 gives q = a, r = 0.
  - a < b gives q = 0, r = a.
  - b = 0xFFFF with a = 0xFFFF gives q = 1, r = 0.
- The R register is WIDTH+1 bits so the intermediate {R, msb} never overflows.

Decomposition:
- Shared package:
  - Constant DIV_WIDTH = 16.
  - State enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10; 11 is illegal and recovers to IDLE.
  - Constant CNT_W = $clog2(WIDTH).
- One natural sub-module, resta_pas: combinational WIDTH+1-bit subtractor computing x + ~y + 1.
  - Outputs the difference and carry-out c (c = 1 means x >= y).
  - The divider instantiates it once for the per-iteration trial subtraction.
- Control FSM and shift registers stay in divisor_seq.

Test Plan:
- Reset, then a = 100, b = 7, start for one cycle → busy high for 16 cycles, then done pulse with q = 14, r = 2, div0 = 0; done is high exactly 1 cycle.
- a = 0xFFFF, b = 1 → q = 0xFFFF, r = 0; then a = 3, b = 10 → q = 0, r = 3; then a = 0xFFFF, b = 0xFFFF → q = 1, r = 0.
- a = 5, b = 0 → done in the cycle after the start edge, q = 0xFFFF, r = 5, div0 = 1, busy never high.
- a = 1000, b = 33 started; at RUN cycle 4 pulse start with a = 9, b = 3 → second request ignored, result q = 30, r = 10; q/r keep the previous result until done.
- Start a = 50000, b = 123, assert rst at RUN cycle 8 → all outputs 0, state IDLE; new start a = 50000, b = 123 → q = 406, r = 62.
- Random sweep of 10k (a, b) pairs with b != 0 → q*b + r == a and r < b for every result, with fixed 17-cycle start-to-done latency.
